// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and helpers for the uart_tx arbiter slice.
// Holds the FSM encoding, byte width and index-width helper.
package uart_tx_arbiter_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SEND  = 2'd1,
      DRAIN = 2'd2,
      GAP   = 2'd3
   } arb_state_e;

   function automatic int id_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Finds the first set request after ptr, wrapping modulo N.
module rr_pick
   import uart_tx_arbiter_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = id_w(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic          found,
   output logic [IW-1:0] idx
);

   logic [IW-1:0] cand;

   // scan upward from ptr+1; the first hit wins
   always_comb begin
      found = 1'b0;
      idx   = '0;
      cand  = '0;
      for (int k = 1; k <= N; k++) begin
         cand = IW'((int'(ptr) + k) % N);
         if (!found && req[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-atomic round-robin arbiter in front of uart_tx.
// One output register, stall watchdog and optional idle gap.
module uart_tx_arbiter
   import uart_tx_arbiter_pkg::*;
#(
   parameter  int NUM_REQ       = 4,
   parameter  int GAP_CYCLES    = 0,
   parameter  int STALL_TIMEOUT = 0,
   localparam int IW            = id_w(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ*BYTE_W-1:0] req_data,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ-1:0]        req_last,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [BYTE_W-1:0]         tx_data,
   output logic                      tx_data_valid,
   input  logic                      tx_data_ready,
   output logic [IW-1:0]             grant_id,
   output logic                      busy,
   output logic                      timeout_pulse
);

   localparam int SW = id_w(STALL_TIMEOUT + 1);
   localparam int GW = id_w(GAP_CYCLES + 1);

   arb_state_e        state;
   arb_state_e        state_nx;
   logic [IW-1:0]     ptr;
   logic [IW-1:0]     winner;
   logic              found;
   logic [SW-1:0]     stall_cnt;
   logic [SW-1:0]     stall_nx;
   logic [GW-1:0]     gap_cnt;
   logic              stall_hit;
   logic              own_valid;
   logic              own_last;
   logic [BYTE_W-1:0] own_data;
   logic              out_free;
   logic              accept;
   logic              xfer;

   assign own_valid = req_valid[grant_id];
   assign own_last  = req_last[grant_id];
   assign own_data  = req_data[BYTE_W*grant_id +: BYTE_W];
   assign out_free  = !tx_data_valid || tx_data_ready;
   assign xfer      = tx_data_valid && tx_data_ready;
   assign accept    = (state == SEND) && own_valid && out_free;
   assign busy      = (state != IDLE);

   assign stall_nx = (state != SEND || own_valid) ? '0 :
                     (&stall_cnt) ? stall_cnt :
                     stall_cnt + 1'b1;

   rr_pick #(
      .N  (NUM_REQ),
      .IW (IW)
   ) u_pick (
      .req   (req_valid),
      .ptr   (ptr),
      .found (found),
      .idx   (winner)
   );

   // only the owner may push, and only when the register can take a byte
   always_comb begin
      req_ready = '0;
      if (state == SEND && out_free) req_ready[grant_id] = 1'b1;
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // next state; a last accept always beats a watchdog expiry
   always_comb begin
      state_nx  = state;
      stall_hit = 1'b0;
      case (state)
         IDLE: if (found) state_nx = SEND;
         SEND: begin
            if (accept && own_last) begin
               state_nx = DRAIN;
            end else if (STALL_TIMEOUT != 0 && !own_valid &&
                         stall_nx == SW'(STALL_TIMEOUT)) begin
               state_nx  = DRAIN;
               stall_hit = 1'b1;
            end
         end
         DRAIN: if (out_free) state_nx = (GAP_CYCLES > 0) ? GAP : IDLE;
         GAP:   if (gap_cnt <= GW'(1)) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // datapath: output register, grant, pointer and counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_data       <= '0;
         tx_data_valid <= 1'b0;
         grant_id      <= '0;
         ptr           <= IW'(NUM_REQ - 1);
         stall_cnt     <= '0;
         gap_cnt       <= '0;
         timeout_pulse <= 1'b0;
      end else begin
         timeout_pulse <= stall_hit;
         stall_cnt     <= stall_nx;
         if (accept) begin
            tx_data       <= own_data;
            tx_data_valid <= 1'b1;
         end else if (xfer) begin
            tx_data_valid <= 1'b0;
         end
         if (state == IDLE && found) begin
            grant_id <= winner;
            ptr      <= winner;
         end
         if (state == DRAIN && out_free) begin
            gap_cnt <= GW'(GAP_CYCLES);
         end else if (state == GAP && gap_cnt > GW'(1)) begin
            gap_cnt <= gap_cnt - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter with a message-level model.
// Expected byte stream is built from round-robin over message lists.
module tb_uart_tx_arbiter;

   localparam int N = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [31:0]  req_data;
   logic [3:0]   req_valid;
   logic [3:0]   req_last;
   logic [3:0]   req_ready;
   logic [7:0]   tx_data;
   logic         tx_data_valid;
   logic         tx_data_ready;
   logic [1:0]   grant_id;
   logic         busy;
   logic         timeout_pulse;

   logic [31:0]  g_req_data;
   logic [3:0]   g_req_valid;
   logic [3:0]   g_req_last;
   logic [3:0]   g_req_ready;
   logic [7:0]   g_tx_data;
   logic         g_tx_valid;
   logic         g_tx_ready;
   logic [1:0]   g_grant_id;
   logic         g_busy;
   logic         g_timeout;

   always #5 clk = ~clk;

   uart_tx_arbiter #(
      .NUM_REQ(4), .GAP_CYCLES(0), .STALL_TIMEOUT(8)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_data(req_data), .req_valid(req_valid),
      .req_last(req_last), .req_ready(req_ready),
      .tx_data(tx_data), .tx_data_valid(tx_data_valid),
      .tx_data_ready(tx_data_ready), .grant_id(grant_id),
      .busy(busy), .timeout_pulse(timeout_pulse)
   );

   uart_tx_arbiter #(
      .NUM_REQ(4), .GAP_CYCLES(5), .STALL_TIMEOUT(0)
   ) dut_g (
      .clk(clk), .rst_n(rst_n),
      .req_data(g_req_data), .req_valid(g_req_valid),
      .req_last(g_req_last), .req_ready(g_req_ready),
      .tx_data(g_tx_data), .tx_data_valid(g_tx_valid),
      .tx_data_ready(g_tx_ready), .grant_id(g_grant_id),
      .busy(g_busy), .timeout_pulse(g_timeout)
   );

   int errors = 0;
   int checks = 0;

   // driver queues and model message lists
   byte unsigned mq[N][$];
   bit           ml[N][$];
   byte unsigned mb[N][$];
   bit           mlq[N][$];
   byte unsigned exp_q[$];
   int           exp_src[$];
   int           own_seq[$];

   int         bub[N];
   bit         fire[N];
   bit         held;
   logic [7:0] held_data;
   int         mptr = N - 1;
   int         rdy_pct = 100;
   int         rdy_lo = 0;
   bit         bub_en = 1'b0;
   bit         to_ok = 1'b0;

   initial begin
      #3000000;
      $display("FAIL global_timeout: bench did not finish");
      $fatal(1);
   end

   task automatic clear_tb();
      for (int r = 0; r < N; r++) begin
         mq[r].delete(); ml[r].delete();
         mb[r].delete(); mlq[r].delete();
         bub[r] = 0; fire[r] = 1'b0;
      end
      exp_q.delete(); exp_src.delete(); own_seq.delete();
      held = 1'b0; rdy_lo = 0; mptr = N - 1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req_valid = '0; req_last = '0; req_data = '0;
      tx_data_ready = 1'b0;
      g_req_valid = '0; g_req_last = '0; g_req_data = '0;
      g_tx_ready = 1'b0;
      repeat (2) @(negedge clk);
      clear_tb();
      rst_n = 1'b1;
   endtask

   task automatic push_byte(input int r, input byte unsigned b,
                            input bit lst);
      mq[r].push_back(b); ml[r].push_back(lst);
      mb[r].push_back(b); mlq[r].push_back(lst);
   endtask

   task automatic load_msg(input int r, input int n, input bit wl);
      for (int i = 0; i < n; i++)
         push_byte(r, 8'($urandom), wl && (i == n - 1));
   endtask

   function automatic bit pending();
      for (int r = 0; r < N; r++)
         if (mq[r].size() > 0) return 1'b1;
      return 1'b0;
   endfunction

   // model: whole messages granted round robin among pending sources
   task automatic build_expected();
      bit any;
      bit lst;
      int c;
      any = 1'b1;
      while (any) begin
         any = 1'b0;
         for (int k = 1; k <= N && !any; k++) begin
            c = (mptr + k) % N;
            if (mb[c].size() > 0) any = 1'b1;
         end
         if (any) begin
            lst = 1'b0;
            while (!lst && mb[c].size() > 0) begin
               exp_q.push_back(mb[c].pop_front());
               exp_src.push_back(c);
               lst = mlq[c].pop_front();
            end
            mptr = c;
         end
      end
   endtask

   // one clock: commit handshakes, drive, then sample and score
   task automatic step();
      bit           lst;
      byte unsigned e;
      int           s;
      logic [3:0]   other;
      @(negedge clk);
      for (int r = 0; r < N; r++) begin
         if (fire[r]) begin
            void'(mq[r].pop_front());
            lst = ml[r].pop_front();
            if (bub_en && !lst) bub[r] = $urandom_range(0, 3);
         end else if (bub[r] > 0) begin
            bub[r]--;
         end
      end
      if (rdy_lo > 0) begin
         tx_data_ready = 1'b0;
         rdy_lo--;
      end else begin
         tx_data_ready = ($urandom_range(0, 99) < rdy_pct);
      end
      for (int r = 0; r < N; r++) begin
         if (mq[r].size() > 0 && bub[r] == 0) begin
            req_valid[r] = 1'b1;
            req_data[8*r +: 8] = mq[r][0];
            req_last[r] = ml[r][0];
         end else begin
            req_valid[r] = 1'b0;
            req_data[8*r +: 8] = 8'($urandom);
            req_last[r] = 1'($urandom);
         end
      end
      #1;
      if (held) begin
         checks++;
         if (tx_data_valid !== 1'b1 || tx_data !== held_data) begin
            errors++;
            $display("FAIL hold: got v=%b d=%02h, required v=1 d=%02h",
                     tx_data_valid, tx_data, held_data);
         end
      end
      other = req_ready & ~(4'b0001 << grant_id);
      checks++;
      if (other != 4'b0 ||
          (req_ready != 4'b0 && tx_data_valid && !tx_data_ready) ||
          (req_ready != 4'b0 && !busy)) begin
         errors++;
         $display("FAIL ready_rule: got req_ready=%b g=%0d v=%b r=%b",
                  req_ready, grant_id, tx_data_valid, tx_data_ready);
      end
      if (!to_ok) begin
         checks++;
         if (timeout_pulse !== 1'b0) begin
            errors++;
            $display("FAIL spurious_timeout: got 1, required 0");
         end
      end
      for (int r = 0; r < N; r++)
         fire[r] = req_valid[r] && req_ready[r];
      if (tx_data_valid && tx_data_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL extra_byte: got %02h, required none", tx_data);
         end else begin
            e = exp_q.pop_front();
            s = exp_src.pop_front();
            if (tx_data !== e || grant_id !== 2'(s)) begin
               errors++;
               $display("FAIL byte_order: got %02h/src%0d, required %02h/src%0d",
                        tx_data, grant_id, e, s);
            end
         end
         if (own_seq.size() == 0 || own_seq[$] != int'(grant_id))
            own_seq.push_back(int'(grant_id));
      end
      held = tx_data_valid && !tx_data_ready;
      held_data = tx_data;
   endtask

   task automatic run_until_done(input int budget, input int mode);
      int n;
      n = 0;
      while ((exp_q.size() > 0 || tx_data_valid === 1'b1 || pending())
             && n < budget) begin
         step();
         if (mode == 1 && mq[0].size() > 0) begin
            checks++;
            if (req_ready[1] !== 1'b0) begin
               errors++;
               $display("FAIL no_interleave: got req_ready[1]=%b, required 0",
                        req_ready[1]);
            end
         end
         n++;
      end
      checks++;
      if (exp_q.size() > 0 || pending()) begin
         errors++;
         $display("FAIL drain: got %0d bytes outstanding, required 0",
                  exp_q.size());
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req_valid = 4'hF; req_last = 4'hF; req_data = 32'hDEADBEEF;
      tx_data_ready = 1'b1;
      g_req_valid = '0; g_req_last = '0; g_req_data = '0;
      g_tx_ready = 1'b1;
      @(negedge clk);
      #1;
      checks++;
      if (tx_data !== 8'h00) begin
         errors++; $display("FAIL rst_tx_data: got %02h, required 00", tx_data);
      end
      checks++;
      if (tx_data_valid !== 1'b0) begin
         errors++; $display("FAIL rst_valid: got %b, required 0", tx_data_valid);
      end
      checks++;
      if (req_ready !== 4'b0) begin
         errors++; $display("FAIL rst_ready: got %b, required 0000", req_ready);
      end
      checks++;
      if (grant_id !== 2'd0) begin
         errors++; $display("FAIL rst_grant: got %0d, required 0", grant_id);
      end
      checks++;
      if (busy !== 1'b0 || timeout_pulse !== 1'b0) begin
         errors++;
         $display("FAIL rst_busy: got busy=%b to=%b, required 0 0",
                  busy, timeout_pulse);
      end
      do_reset();
   endtask

   task automatic test_single();
      int n;
      do_reset();
      rdy_pct = 100; bub_en = 1'b0;
      push_byte(0, 8'h4F, 1'b0);
      push_byte(0, 8'h4B, 1'b0);
      push_byte(0, 8'h0A, 1'b1);
      build_expected();
      n = 0;
      while (exp_q.size() > 0 && n < 50) begin
         step(); n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL single_bytes: got %0d missing, required 0",
                  exp_q.size());
      end
      checks++;
      if (busy !== 1'b1) begin
         errors++; $display("FAIL single_busy_drain: got %b, required 1", busy);
      end
      step();
      checks++;
      if (busy !== 1'b0 || grant_id !== 2'd0) begin
         errors++;
         $display("FAIL single_busy_fall: got busy=%b g=%0d, required 0 0",
                  busy, grant_id);
      end
   endtask

   task automatic test_simultaneous();
      do_reset();
      rdy_pct = 70;
      load_msg(0, 4, 1'b1);
      load_msg(1, 4, 1'b1);
      build_expected();
      run_until_done(200, 1);
   endtask

   task automatic test_fairness();
      int want[4] = '{0, 2, 0, 2};
      bit bad;
      do_reset();
      rdy_pct = $urandom_range(60, 100);
      load_msg(0, 2, 1'b1); load_msg(2, 2, 1'b1);
      load_msg(0, 2, 1'b1); load_msg(2, 2, 1'b1);
      build_expected();
      run_until_done(300, 0);
      bad = (own_seq.size() != 4);
      for (int i = 0; i < 4 && !bad; i++)
         if (own_seq[i] != want[i]) bad = 1'b1;
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL rr_sequence: got %p, required 0,2,0,2", own_seq);
      end
   endtask

   task automatic test_backpressure();
      int n;
      do_reset();
      rdy_pct = 100;
      load_msg(1, 6, 1'b1);
      load_msg(2, 3, 1'b1);
      build_expected();
      n = 0;
      while (tx_data_valid !== 1'b1 && n < 20) begin
         step(); n++;
      end
      rdy_lo = 20;
      run_until_done(300, 0);
   endtask

   task automatic test_stall();
      int n;
      int last_v;
      int pulse_at;
      int pulse_cnt;
      do_reset();
      rdy_pct = 100; to_ok = 1'b1;
      load_msg(1, 2, 1'b0);
      load_msg(3, 2, 1'b1);
      build_expected();
      n = 0; last_v = -100; pulse_at = -1; pulse_cnt = 0;
      while ((exp_q.size() > 0 || tx_data_valid === 1'b1) && n < 100) begin
         step();
         if (req_valid[1] === 1'b1) last_v = n;
         if (timeout_pulse === 1'b1) begin
            pulse_cnt++;
            if (pulse_at < 0) pulse_at = n;
         end
         n++;
      end
      to_ok = 1'b0;
      // 8 silent cycles after the last valid, pulse registered at that edge
      checks++;
      if (pulse_at - last_v != 9) begin
         errors++;
         $display("FAIL stall_timing: got offset %0d, required 9",
                  pulse_at - last_v);
      end
      checks++;
      if (pulse_cnt != 1) begin
         errors++;
         $display("FAIL stall_pulse_width: got %0d, required 1", pulse_cnt);
      end
      checks++;
      if (exp_q.size() != 0 || grant_id !== 2'd3) begin
         errors++;
         $display("FAIL stall_handover: got g=%0d left=%0d, required g=3 left=0",
                  grant_id, exp_q.size());
      end
   endtask

   task automatic test_random();
      for (int rnd = 0; rnd < 4; rnd++) begin
         bub_en = 1'b1;
         rdy_pct = $urandom_range(40, 100);
         for (int r = 0; r < N; r++) begin
            int k;
            k = $urandom_range(0, 2);
            for (int m = 0; m < k; m++)
               load_msg(r, $urandom_range(1, 5), 1'b1);
         end
         build_expected();
         run_until_done(1500, 0);
      end
      bub_en = 1'b0;
   endtask

   task automatic test_gap();
      byte unsigned a;
      byte unsigned b;
      byte unsigned got[$];
      int  idx;
      int  xfer_at;
      int  gapn;
      bit  seen_idle;
      bit  gfire;
      int  n;
      do_reset();
      a = 8'($urandom); b = 8'($urandom);
      idx = 0; xfer_at = -1; gapn = 0; seen_idle = 1'b0;
      gfire = 1'b0; n = 0;
      while (n < 60 && got.size() < 2) begin
         @(negedge clk);
         if (gfire) idx++;
         g_tx_ready = 1'b1;
         g_req_valid = (idx < 2) ? 4'b0001 : 4'b0000;
         g_req_last = 4'b0001;
         g_req_data = {24'h0, (idx == 0) ? a : b};
         #1;
         gfire = g_req_valid[0] && g_req_ready[0];
         if (xfer_at >= 0 && got.size() == 1 && !seen_idle) begin
            if (g_busy) gapn++;
            else seen_idle = 1'b1;
         end
         if (g_tx_valid && g_tx_ready) begin
            got.push_back(g_tx_data);
            if (got.size() == 1) xfer_at = n;
         end
         n++;
      end
      checks++;
      if (got.size() != 2) begin
         errors++;
         $display("FAIL gap_count_bytes: got %0d, required 2", got.size());
      end else begin
         checks++;
         if (got[0] !== a || got[1] !== b) begin
            errors++;
            $display("FAIL gap_bytes: got %02h %02h, required %02h %02h",
                     got[0], got[1], a, b);
         end
      end
      checks++;
      if (gapn != 5 || !seen_idle) begin
         errors++;
         $display("FAIL gap_len: got %0d idle=%b, required 5 idle=1",
                  gapn, seen_idle);
      end
   endtask

   task automatic test_reset_mid();
      int n;
      do_reset();
      rdy_pct = 100;
      load_msg(1, 6, 1'b1);
      build_expected();
      n = 0;
      while (tx_data_valid !== 1'b1 && n < 20) begin
         step(); n++;
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (tx_data_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: got v=%b busy=%b, required 0 0",
                  tx_data_valid, busy);
      end
      checks++;
      if (req_ready !== 4'b0 || grant_id !== 2'd0) begin
         errors++;
         $display("FAIL async_reset_grant: got rdy=%b g=%0d, required 0000 0",
                  req_ready, grant_id);
      end
      @(negedge clk);
      clear_tb();
      req_valid = '0;
      rst_n = 1'b1;
      load_msg(3, 2, 1'b1);
      load_msg(1, 2, 1'b1);
      load_msg(0, 2, 1'b1);
      build_expected();
      run_until_done(300, 0);
      checks++;
      if (own_seq.size() == 0 || own_seq[0] != 0) begin
         errors++;
         $display("FAIL post_reset_grant: got %p, required first 0", own_seq);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_simultaneous();
      test_fairness();
      test_backpressure();
      test_stall();
      test_random();
      test_gap();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_tx byte sender between NUM_REQ independent message sources, such as status printers and the SD-card dump path.
- Grants are message-atomic: once a requester wins, its whole message (bytes up to req_last) goes out before any other requester can send. Bytes from different sources never interleave.
- Round-robin arbitration between messages. Optional idle gap between messages. A stall watchdog releases the grant if the owner goes silent.
- Sits between the message generators and uart_tx, driving its tx_data/tx_data_valid/tx_data_ready handshake.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- GAP_CYCLES, 0, idle clk cycles forced between messages; 0 means no gap.
- STALL_TIMEOUT, 0, cycles the owner may hold the grant with req_valid low before forced release; 0 disables the watchdog.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset.
- req_data  in  NUM_REQ*8  byte per requester; requester i uses [8i+7:8i].
- req_valid  in  NUM_REQ  requester byte valid.
- req_last  in  NUM_REQ  qualifies the byte as the final byte of the message.
- req_ready  out  NUM_REQ  byte accepted when valid and ready are both high.
- tx_data  out  8  byte to uart_tx.
- tx_data_valid  out  1  byte valid to uart_tx.
- tx_data_ready  in  1  uart_tx ready.
- grant_id  out  clog2(NUM_REQ)  current or most recent owner.
- busy  out  1  high in every state except IDLE.
- timeout_pulse  out  1  one-cycle pulse on watchdog release.

Behaviour:
- Clock and reset: single clock clk. rst_n is asynchronous and active-low.
- Reset values: tx_data=0, tx_data_valid=0, req_ready=0, grant_id=0, busy=0, timeout_pulse=0, state=IDLE.
  - The round-robin pointer resets to NUM_REQ-1, so requester 0 has first priority.
- Output stage: one register.
  - A uart_tx transfer occurs when tx_data_valid and tx_data_ready are both high.
  - tx_data_valid stays high and tx_data stays stable until that transfer.
  - On a transfer with no new accept in the same cycle, tx_data_valid goes to 0.
- req_ready[i] is combinational: state==SEND, i==grant_id, and (tx_data_valid==0 or tx_data_ready==1). All other bits are 0.
- Accept: req_valid[g] && req_ready[g] loads tx_data<=req_data[g] and sets tx_data_valid<=1 on the next edge. This gives full throughput, back-to-back with uart_tx.
- IDLE:
  - If any req_valid is high, pick the first set bit searching upward from pointer+1, wrapping modulo NUM_REQ.
  - grant_id<=winner, pointer<=winner, go to SEND.
  - One cycle of arbitration latency; no byte is accepted in IDLE.
- SEND:
  - Accept bytes from grant_id.
  - An accept with req_last[g]=1 goes to DRAIN.
  - A stall counter counts consecutive SEND cycles with req_valid[g]=0 and clears on any req_valid[g]=1.
  - When STALL_TIMEOUT!=0 and the counter reaches STALL_TIMEOUT: go to DRAIN and pulse timeout_pulse. A partial message is not completed.
- DRAIN: wait until the output register is empty (tx_data_valid==0, or a transfer this cycle). Then go to GAP if GAP_CYCLES>0, else to IDLE.
- GAP: load a counter with GAP_CYCLES and decrement each cycle; go to IDLE on reaching 1. Total time spent in GAP is exactly GAP_CYCLES cycles.
- Simultaneous events:
  - Last accept and a stall-counter expiry in the same cycle: the last accept wins and no timeout_pulse is issued.
  - A requester asserting req_valid while another owns the grant simply waits; its valid must remain high until it is granted.
- Single-byte message (req_last on the first byte): legal. Sequence is SEND for one accept cycle, then DRAIN.
- Non-owner req_valid/req_last are ignored and never reach tx_data.
- Reset mid-message: everything returns to reset values immediately and the byte held in the output register is dropped. uart_tx shares rst_n.
- Widths: the stall counter is clog2(STALL_TIMEOUT+1) bits and the gap counter is clog2(GAP_CYCLES+1) bits; both saturate and never wrap.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE, SEND, DRAIN, GAP);
  - the ID-width helper (clog2);
  - the byte width constant (8).
- One sub-module: rr_pick.
  - Purely combinational round-robin priority picker.
  - Inputs: req vector and pointer. Outputs: found flag and winner index.
  - Reused later by other shared-resource arbiters (e.g. the SD command port).

Test Plan:
- Single message: req0 sends "O","K",0x0A with last on 0x0A, tx_data_ready always 1 → uart_tx sees exactly 0x4F, 0x4B, 0x0A in order; busy falls 1 cycle after the drain transfer; grant_id=0.
- Simultaneous messages: req0 and req1 raise valid in the same cycle, each with a 4-byte message → all 4 req0 bytes, then all 4 req1 bytes, with no interleave; req_ready[1]=0 throughout req0's message.
- Round-robin fairness: req0 and req2 each send continuous 2-byte messages → grant_id sequence 0,2,0,2; requester 0 never wins twice in a row while req2 is pending.
- Backpressure: tx_data_ready low for 20 cycles while tx_data_valid is high → tx_data holds its value, req_ready[g]=0, and no byte is lost or duplicated after ready returns.
- Stall watchdog: STALL_TIMEOUT=8; req1 sends 2 bytes without last, then drops valid → timeout_pulse exactly 8 cycles after the last valid; grant passes to a pending req3; only 2 bytes from req1 reach the output.
- Gap and reset: GAP_CYCLES=5; two back-to-back 1-byte messages → 5 idle cycles between the drain transfer and the next IDLE arbitration. Separately, rst_n asserted mid-message → tx_data_valid=0 and busy=0 asynchronously, and the next grant goes to req0.
